// File: rtl/mcs51_mon_pkg.sv
// Shared types and constants for the mcs51 test monitor.
// FSM states, result encoding and CRC-16/CCITT-FALSE constants.
package mcs51_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    RD,
    EMIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL,
    RES_TIMEOUT
  } result_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/mcs51_crc16_byte.sv
// One-byte combinational CRC-16/CCITT step, MSB first.
// Ports: crc (current), data (byte), crc_next (updated).
module mcs51_crc16_byte
  import mcs51_mon_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] c;

  always_comb begin
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = (c << 1) ^ CRC16_POLY;
      else       c = c << 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/mcs51_test_monitor.sv
// Completion monitor + XDATA window dump engine for mcs51 regressions.
// Ports: start/cfg_* config, xw_* snoop, mem_rd_* read port,
//   dump_* valid/ready beat stream, busy/done/pass/fail/timeout status,
//   cycle_count; signature[15:0] only with MCS51_MON_SIGNATURE_EN.
module mcs51_test_monitor
  import mcs51_mon_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter int                DATA_W        = 8,
  parameter int                CYCLE_W       = 32,
  parameter logic [ADDR_W-1:0] SENTINEL_ADDR = 16'hFFFE,
  parameter logic [DATA_W-1:0] PASS_CODE     = 8'hA5,
  parameter logic [DATA_W-1:0] FAIL_CODE     = 8'h5A
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_begin,
  input  logic [ADDR_W-1:0]  cfg_end,
  input  logic [CYCLE_W-1:0] cfg_max,
  input  logic               xw_en,
  input  logic [ADDR_W-1:0]  xw_addr,
  input  logic [DATA_W-1:0]  xw_data,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               dump_last,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count
`ifdef MCS51_MON_SIGNATURE_EN
  ,
  output logic [15:0]        signature
`endif
);

  state_t            state, state_n;
  result_t           res;
  logic [ADDR_W-1:0] beg_q, end_q, addr;
  logic [CYCLE_W-1:0] max_q;
  logic [DATA_W-1:0] beat_q;
  logic              fresh, done_q;
  logic              hit, is_pass, is_fail, tmo;
  logic              go, hs, last;

  assign hit     = xw_en && (xw_addr == SENTINEL_ADDR);
  assign is_pass = hit && (xw_data == PASS_CODE);
  assign is_fail = hit && (xw_data == FAIL_CODE);
  assign tmo     = (max_q != '0) &&
                   (cycle_count == max_q - 1'b1);
  assign go      = start &&
                   (state == IDLE || state == DONE);
  assign hs      = (state == EMIT) && dump_ready;
  // compared before increment so an all-ones end never wraps
  assign last    = (addr == end_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = RUN;
      RUN: begin
        if (is_pass || is_fail || tmo)
          state_n = (beg_q > end_q) ? DONE : RD;
      end
      RD:   state_n = EMIT;
      EMIT: begin
        if (dump_ready) state_n = last ? DONE : RD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res         <= RES_NONE;
      beg_q       <= '0;
      end_q       <= '0;
      max_q       <= '0;
      addr        <= '0;
      beat_q      <= '0;
      fresh       <= 1'b0;
      done_q      <= 1'b0;
      cycle_count <= '0;
    end else begin
      fresh <= 1'b0;
      if (go) begin
        beg_q       <= cfg_begin;
        end_q       <= cfg_end;
        max_q       <= cfg_max;
        addr        <= cfg_begin;
        cycle_count <= '0;
        res         <= RES_NONE;
        done_q      <= 1'b0;
      end
      if (state == RUN) begin
        cycle_count <= cycle_count + 1'b1;
        if (is_pass)      res <= RES_PASS;
        else if (is_fail) res <= RES_FAIL;
        else if (tmo)     res <= RES_TIMEOUT;
        if (state_n == DONE) done_q <= 1'b1;
      end
      if (state == RD) fresh  <= 1'b1;
      if (fresh)       beat_q <= mem_rd_data;
      if (hs) begin
        if (last) done_q <= 1'b1;
        else      addr   <= addr + 1'b1;
      end
    end
  end

  // read data lands in the first EMIT cycle; forward it,
  // then hold the captured copy while the sink stalls
  assign dump_data   = fresh ? mem_rd_data : beat_q;
  assign dump_valid  = (state == EMIT);
  assign dump_addr   = addr;
  assign dump_last   = dump_valid && last;
  assign mem_rd_en   = (state == RD);
  assign mem_rd_addr = addr;
  assign busy        = state inside {RUN, RD, EMIT};
  assign done        = done_q;
  assign pass        = (res == RES_PASS);
  assign fail        = (res == RES_FAIL);
  assign timeout     = (res == RES_TIMEOUT);

`ifdef MCS51_MON_SIGNATURE_EN
  logic [15:0] crc_next;

  mcs51_crc16_byte u_crc (
    .crc      (signature),
    .data     (dump_data),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  signature <= CRC16_INIT;
    else if (go)   signature <= CRC16_INIT;
    else if (hs)   signature <= crc_next;
  end
`endif

endmodule

// File: tb/tb_mcs51_test_monitor.sv
// Scoreboard bench for mcs51_test_monitor.
// Beats are queued at start and popped on each handshake.
module tb_mcs51_test_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_begin = '0;
  logic [15:0] cfg_end = '0;
  logic [31:0] cfg_max = '0;
  logic        xw_en = 1'b0;
  logic [15:0] xw_addr = '0;
  logic [7:0]  xw_data = '0;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [15:0] dump_addr;
  logic [7:0]  dump_data;
  logic        dump_last;
  logic        busy, done, pass, fail, timeout;
  logic [31:0] cycle_count;
`ifdef MCS51_MON_SIGNATURE_EN
  logic [15:0] signature;
`endif

  mcs51_test_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cfg_begin   (cfg_begin),
    .cfg_end     (cfg_end),
    .cfg_max     (cfg_max),
    .xw_en       (xw_en),
    .xw_addr     (xw_addr),
    .xw_data     (xw_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_last   (dump_last),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .cycle_count (cycle_count)
`ifdef MCS51_MON_SIGNATURE_EN
    ,
    .signature   (signature)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_errors = 0;
  int          beats = 0;
  int          ready_mode = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // synchronous 1-cycle read port
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dump_ready = 1'b1;
      1:       dump_ready = 1'($urandom_range(0, 1));
      default: dump_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(dump_valid), 32'd1);
        check("stall_addr", 32'(dump_addr), 32'(prev_addr));
        check("stall_data", 32'(dump_data), 32'(prev_data));
        check("stall_last", 32'(dump_last), 32'(prev_last));
      end
      if (dump_valid && dump_ready) begin
        beat_t e;
        beats++;
        if (exp_q.size() == 0) begin
          check("beat_extra", 32'(dump_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", 32'(dump_addr), 32'(e.a));
          check("beat_data", 32'(dump_data), 32'(e.d));
          check("beat_last", 32'(dump_last), 32'(e.l));
        end
      end
      stall_prev = dump_valid && !dump_ready;
      prev_addr  = dump_addr;
      prev_data  = dump_data;
      prev_last  = dump_last;
    end
  end

  task automatic run(input logic [15:0] b,
                     input logic [15:0] e,
                     input logic [31:0] mx);
    for (int a = int'(b); a <= int'(e); a++) begin
      beat_t x;
      x.a = 16'(a);
      x.d = mem[a];
      x.l = (a == int'(e));
      exp_q.push_back(x);
    end
    beats = 0;
    @(negedge clk);
    cfg_begin = b;
    cfg_end   = e;
    cfg_max   = mx;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic sentinel(input logic [7:0] d,
                          input int at);
    int ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy && cycle_count == 32'(at)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("sent_wait", 32'(ok), 32'd1);
    xw_en   = 1'b1;
    xw_addr = 16'hFFFE;
    xw_data = d;
    @(posedge clk);
    #1 xw_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done", 32'(done), 32'd1);
    check("not_busy", 32'(busy), 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22;
    mem[2] = 8'h33; mem[3] = 8'h44;
    for (int i = 0; i < 9; i++) mem[16'h100 + i] = 8'h31 + 8'(i);

    repeat (3) @(negedge clk);
    check("rst_flags",
          32'({busy, done, pass, fail, timeout,
               dump_valid, dump_last, mem_rd_en}), 32'd0);
    check("rst_cnt", cycle_count, 32'd0);
    check("rst_addr", 32'(dump_addr), 32'd0);
    reset_n = 1'b1;

    // pass sentinel at RUN cycle 100
    ready_mode = 0;
    run(16'h0000, 16'h0003, 32'd0);
    sentinel(8'hA5, 100);
    wait_done();
    check("t1_pass", 32'({pass, fail, timeout}), 32'b100);
    check("t1_cnt", cycle_count, 32'd101);
    check("t1_beats", 32'(beats), 32'd4);

    // timeout, then late fail write ignored
    run(16'h0004, 16'h0005, 32'd50);
    wait_done();
    check("t2_tmo", 32'({pass, fail, timeout}), 32'b001);
    check("t2_cnt", cycle_count, 32'd50);
    xw_en = 1'b1; xw_addr = 16'hFFFE; xw_data = 8'h5A;
    @(negedge clk);
    xw_en = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_late", 32'({pass, fail, timeout}), 32'b001);
    check("t2_frozen", cycle_count, 32'd50);

    // sentinel and timeout collide
    run(16'h0020, 16'h0021, 32'd30);
    sentinel(8'h5A, 29);
    wait_done();
    check("t3_fail", 32'({pass, fail, timeout}), 32'b010);
    check("t3_cnt", cycle_count, 32'd30);

    // top-of-memory window, random backpressure
    ready_mode = 1;
    run(16'hFFFC, 16'hFFFF, 32'd0);
    sentinel(8'hA5, 3);
    wait_done();
    check("t4_beats", 32'(beats), 32'd4);
    check("t4_nowrap", 32'(dump_addr), 32'hFFFF);

`ifdef MCS51_MON_SIGNATURE_EN
    ready_mode = 0;
    run(16'h0100, 16'h0108, 32'd0);
    sentinel(8'hA5, 5);
    wait_done();
    check("t6_sig", 32'(signature), 32'h29B1);
`endif

    // empty window
    ready_mode = 0;
    run(16'h0010, 16'h000F, 32'd5);
    wait_done();
    check("t5_beats", 32'(beats), 32'd0);
    check("t5_tmo", 32'(timeout), 32'd1);

    // reset while a beat is held
    ready_mode = 2;
    run(16'h0000, 16'h0003, 32'd3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dump_valid) break;
    end
    check("t5_valid", 32'(dump_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_flags",
          32'({busy, done, pass, fail, timeout,
               dump_valid, dump_last, mem_rd_en}), 32'd0);
    check("t5_rst_bus",
          32'({dump_addr, dump_data}), 32'd0);
    check("t5_rst_cnt", cycle_count, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle", 32'({busy, dump_valid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
